// File: rtl/colorbar_ddr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : colorbar_ddr_ctrl
//  Description : Writes one 8-bar RGB565 colour-bar frame through the MIG app
//                interface, reads it back and counts mismatching beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module colorbar_ddr_ctrl #(
    parameter int                BAR_W     = 8,
    parameter int                V_LINES   = 4,
    parameter int                ADDR_W    = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [127:0]      app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [15:0]       app_wdf_mask,
    output logic              wr_done,
    output logic              rd_done,
    output logic [15:0]       err_cnt,
    output logic              err_flag
);

    localparam int                WPB       = BAR_W / 8;
    localparam int                WIB_W     = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int                LN_W      = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [WIB_W-1:0]  WIB_LAST  = WIB_W'(WPB - 1);
    localparam logic [LN_W-1:0]   LN_LAST   = LN_W'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(8);
    localparam logic [2:0]        CMD_WR    = 3'b000;
    localparam logic [2:0]        CMD_RD    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [127:0]       wdata_q, wdata_d;
    logic               wren_q, wren_d;
    logic               cmd_ok_q, cmd_ok_d;
    logic               dat_ok_q, dat_ok_d;
    logic [WIB_W-1:0]   g_wib_q, g_wib_d;
    logic [2:0]         g_bar_q, g_bar_d;
    logic [LN_W-1:0]    g_ln_q, g_ln_d;
    logic [WIB_W-1:0]   c_wib_q, c_wib_d;
    logic [2:0]         c_bar_q, c_bar_d;
    logic [LN_W-1:0]    c_ln_q, c_ln_d;
    logic               wr_done_q, wr_done_d;
    logic               rd_done_q, rd_done_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic               err_flag_q, err_flag_d;

    logic               gen_last, chk_last, chk_active;
    logic               cmd_done, dat_done;
    logic [WIB_W-1:0]   g_wib_nx;
    logic [2:0]         g_bar_nx;
    logic [LN_W-1:0]    g_ln_nx;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            cmd_q      <= CMD_WR;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            cmd_ok_q   <= 1'b0;
            dat_ok_q   <= 1'b0;
            g_wib_q    <= '0;
            g_bar_q    <= '0;
            g_ln_q     <= '0;
            c_wib_q    <= '0;
            c_bar_q    <= '0;
            c_ln_q     <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            cmd_ok_q   <= cmd_ok_d;
            dat_ok_q   <= dat_ok_d;
            g_wib_q    <= g_wib_d;
            g_bar_q    <= g_bar_d;
            g_ln_q     <= g_ln_d;
            c_wib_q    <= c_wib_d;
            c_bar_q    <= c_bar_d;
            c_ln_q     <= c_ln_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = wren_q;
        cmd_ok_d   = cmd_ok_q;
        dat_ok_d   = dat_ok_q;
        g_wib_d    = g_wib_q;
        g_bar_d    = g_bar_q;
        g_ln_d     = g_ln_q;
        c_wib_d    = c_wib_q;
        c_bar_d    = c_bar_q;
        c_ln_d     = c_ln_q;
        wr_done_d  = wr_done_q;
        rd_done_d  = rd_done_q;
        err_cnt_d  = err_cnt_q;

        // Generator position after the current word (line wraps only past the last word)
        gen_last = (g_wib_q == WIB_LAST) && (g_bar_q == 3'd7) && (g_ln_q == LN_LAST);
        g_wib_nx = (g_wib_q == WIB_LAST) ? '0 : g_wib_q + WIB_W'(1);
        g_bar_nx = (g_wib_q == WIB_LAST) ? g_bar_q + 3'd1 : g_bar_q;
        g_ln_nx  = ((g_wib_q == WIB_LAST) && (g_bar_q == 3'd7)) ? g_ln_q + LN_W'(1) : g_ln_q;

        cmd_done = cmd_ok_q | (en_q & app_rdy);
        dat_done = dat_ok_q | (wren_q & app_wdf_rdy);

        // Read-back checker runs independently of the command side
        chk_last   = (c_wib_q == WIB_LAST) && (c_bar_q == 3'd7) && (c_ln_q == LN_LAST);
        chk_active = ((state_q == S_RD) || (state_q == S_CHK)) && !rd_done_q;
        if (chk_active && app_rd_data_valid) begin
            if ((app_rd_data != {8{bar_color(c_bar_q)}}) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (chk_last) begin
                rd_done_d = 1'b1;
            end else begin
                c_wib_d = (c_wib_q == WIB_LAST) ? '0 : c_wib_q + WIB_W'(1);
                c_bar_d = (c_wib_q == WIB_LAST) ? c_bar_q + 3'd1 : c_bar_q;
                c_ln_d  = ((c_wib_q == WIB_LAST) && (c_bar_q == 3'd7)) ? c_ln_q + LN_W'(1) : c_ln_q;
            end
        end
        err_flag_d = (err_cnt_d != 16'd0);

        case (state_q)
            S_IDLE: begin
                if (init_calib_complete) begin
                    state_d  = S_WR;
                    en_d     = 1'b1;
                    cmd_d    = CMD_WR;
                    addr_d   = BASE_ADDR;
                    wren_d   = 1'b1;
                    wdata_d  = {8{bar_color(g_bar_q)}};
                    cmd_ok_d = 1'b0;
                    dat_ok_d = 1'b0;
                end
            end
            S_WR: begin
                if (cmd_done && dat_done) begin
                    cmd_ok_d = 1'b0;
                    dat_ok_d = 1'b0;
                    en_d     = 1'b1;
                    if (gen_last) begin
                        state_d   = S_RD;
                        wr_done_d = 1'b1;
                        cmd_d     = CMD_RD;
                        addr_d    = BASE_ADDR;
                        wren_d    = 1'b0;
                        g_wib_d   = '0;
                        g_bar_d   = '0;
                        g_ln_d    = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        wren_d  = 1'b1;
                        wdata_d = {8{bar_color(g_bar_nx)}};
                        g_wib_d = g_wib_nx;
                        g_bar_d = g_bar_nx;
                        g_ln_d  = g_ln_nx;
                    end
                end else begin
                    // The side already accepted drops its valid and waits for the other
                    cmd_ok_d = cmd_done;
                    en_d     = !cmd_done;
                    dat_ok_d = dat_done;
                    wren_d   = !dat_done;
                end
            end
            S_RD: begin
                if (en_q && app_rdy) begin
                    if (gen_last) begin
                        en_d    = 1'b0;
                        state_d = S_CHK;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        g_wib_d = g_wib_nx;
                        g_bar_d = g_bar_nx;
                        g_ln_d  = g_ln_nx;
                    end
                end
            end
            S_CHK: begin
                if (rd_done_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign app_en       = en_q;
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_mask = 16'h0000;
    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;
    assign err_cnt      = err_cnt_q;
    assign err_flag     = err_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_colorbar_ddr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_colorbar_ddr_ctrl
//  Description : Scoreboard bench with a loopback MIG memory stub for
//                colorbar_ddr_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_colorbar_ddr_ctrl;

    localparam int BAR_W   = 8;
    localparam int V_LINES = 4;
    localparam int ADDR_W  = 28;
    localparam int NWORDS  = BAR_W * V_LINES;
    localparam logic [ADDR_W-1:0] BASE = '0;
    localparam logic [15:0] PAL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic              sysclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              calib = 1'b0;
    logic              app_rdy = 1'b0;
    logic              app_wdf_rdy = 1'b0;
    logic [127:0]      app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [127:0]      app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [15:0]       app_wdf_mask;
    logic              wr_done;
    logic              rd_done;
    logic [15:0]       err_cnt;
    logic              err_flag;

    colorbar_ddr_ctrl #(.BAR_W(BAR_W), .V_LINES(V_LINES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .init_calib_complete(calib),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .wr_done(wr_done), .rd_done(rd_done),
        .err_cnt(err_cnt), .err_flag(err_flag)
    );

    initial forever #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference pattern straight from the bar definition
    function automatic logic [127:0] exp_word(input int n);
        int b;
        b = (n % BAR_W) / (BAR_W / 8);
        return {8{PAL[b]}};
    endfunction

    logic [ADDR_W-1:0] exp_wcmd[$];
    logic [127:0]      exp_wdat[$];
    logic [ADDR_W-1:0] exp_rcmd[$];

    int           st_waddr[$];
    logic [127:0] st_wdat[$];
    logic [127:0] mem [int];
    int           pend_t[$];
    int           pend_a[$];
    bit           corrupt [NWORDS];

    int cyc = 0, lat = 20, rdy_pct = 100, bp_mode = 0, bp_cnt = 0, bp_stall = 0, bp_wren = 0;
    int extra_beats = 0, beat_idx = 0, last_beat_cyc = -1;
    int first_wcmd = -1, last_wcmd = -1, last_wdat = -1, first_rcmd = -1, last_rcmd = -1;
    int wr_done_cyc = -1, rd_done_cyc = -1;

    // Input driver and memory stub return path
    initial begin
        int a, bitpos;
        logic [127:0] d;
        forever begin
            @(posedge sysclk); #1;
            cyc++;
            if (bp_mode != 0) begin
                app_wdf_rdy = 1'b1;
                if (app_en && app_cmd == 3'b000 && app_addr == ADDR_W'(24) && bp_cnt < 5) begin
                    app_rdy = 1'b0;
                    bp_cnt++;
                end else begin
                    app_rdy = 1'b1;
                end
            end else begin
                app_rdy     = ($urandom_range(99) < rdy_pct);
                app_wdf_rdy = ($urandom_range(99) < rdy_pct);
            end
            if (pend_t.size() != 0 && pend_t[0] <= cyc) begin
                void'(pend_t.pop_front());
                a = pend_a.pop_front();
                d = mem.exists(a) ? mem[a] : '0;
                if (beat_idx < NWORDS && corrupt[beat_idx]) begin
                    bitpos = $urandom_range(127);
                    d[bitpos] = ~d[bitpos];
                end
                app_rd_data_valid = 1'b1;
                app_rd_data = d;
                beat_idx++;
                last_beat_cyc = cyc;
            end else if (extra_beats > 0) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
                extra_beats--;
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: scoreboard pops, hold rules, stub write capture
    initial begin
        logic              prev_en, prev_rdy, prev_wren, prev_wrdy;
        logic [2:0]        prev_cmd;
        logic [ADDR_W-1:0] prev_addr;
        logic [127:0]      prev_wdata;
        prev_en = 0; prev_rdy = 0; prev_wren = 0; prev_wrdy = 0;
        prev_cmd = '0; prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge sysclk);
            if (!rst_n) begin
                prev_en = 0;
                prev_wren = 0;
            end else begin
                if (prev_en && !prev_rdy)
                    check("cmd_hold", {app_en, app_cmd, app_addr}, {1'b1, prev_cmd, prev_addr});
                if (prev_wren && !prev_wrdy)
                    check("wdata_hold", {app_wdf_wren, app_wdf_data}, {1'b1, prev_wdata});
                if (app_wdf_wren || app_wdf_end)
                    check("wdf_end", app_wdf_end, app_wdf_wren);
                if (bp_mode != 0 && app_en && !app_rdy && app_cmd == 3'b000 && app_addr == ADDR_W'(24)) begin
                    bp_stall++;
                    if (app_wdf_wren) bp_wren++;
                end
                if (app_en && app_rdy) begin
                    if (app_cmd == 3'b000) begin
                        check("wcmd_expected", exp_wcmd.size() != 0, 1);
                        if (exp_wcmd.size() != 0) check("wcmd_addr", app_addr, exp_wcmd.pop_front());
                        if (first_wcmd < 0) first_wcmd = cyc;
                        last_wcmd = cyc;
                        st_waddr.push_back(int'(app_addr));
                    end else begin
                        check("rcmd_expected", exp_rcmd.size() != 0, 1);
                        if (exp_rcmd.size() != 0)
                            check("rcmd_addr", {app_cmd, app_addr}, {3'b001, exp_rcmd.pop_front()});
                        if (first_rcmd < 0) first_rcmd = cyc;
                        last_rcmd = cyc;
                        pend_t.push_back(cyc + lat);
                        pend_a.push_back(int'(app_addr));
                    end
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    check("wdat_expected", exp_wdat.size() != 0, 1);
                    if (exp_wdat.size() != 0) check("wdat_value", app_wdf_data, exp_wdat.pop_front());
                    last_wdat = cyc;
                    st_wdat.push_back(app_wdf_data);
                end
                while (st_waddr.size() != 0 && st_wdat.size() != 0)
                    mem[st_waddr.pop_front()] = st_wdat.pop_front();
                if (wr_done && wr_done_cyc < 0) wr_done_cyc = cyc;
                if (rd_done && rd_done_cyc < 0) rd_done_cyc = cyc;
                prev_en = app_en; prev_rdy = app_rdy; prev_cmd = app_cmd; prev_addr = app_addr;
                prev_wren = app_wdf_wren; prev_wrdy = app_wdf_rdy; prev_wdata = app_wdf_data;
            end
        end
    end

    task automatic prepare_run(input int latency, input int pct);
        exp_wcmd.delete(); exp_wdat.delete(); exp_rcmd.delete();
        st_waddr.delete(); st_wdat.delete(); mem.delete();
        pend_t.delete(); pend_a.delete();
        for (int n = 0; n < NWORDS; n++) begin
            exp_wcmd.push_back(BASE + ADDR_W'(8 * n));
            exp_wdat.push_back(exp_word(n));
            exp_rcmd.push_back(BASE + ADDR_W'(8 * n));
            corrupt[n] = 1'b0;
        end
        lat = latency; rdy_pct = pct; bp_mode = 0; bp_cnt = 0; bp_stall = 0; bp_wren = 0;
        extra_beats = 0; beat_idx = 0; last_beat_cyc = -1;
        first_wcmd = -1; last_wcmd = -1; last_wdat = -1; first_rcmd = -1; last_rcmd = -1;
        wr_done_cyc = -1; rd_done_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge sysclk); #2;
        rst_n = 1'b0;
        calib = 1'b0;
        repeat (2) @(posedge sysclk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_run(input int exp_err, input bit full_rate);
        int k;
        int wr_last;
        k = 0;
        while (!rd_done && k < 5000) begin
            @(negedge sysclk);
            k++;
        end
        @(negedge sysclk);
        wr_last = (last_wcmd > last_wdat) ? last_wcmd : last_wdat;
        check("rd_done", rd_done, 1);
        check("wr_done", wr_done, 1);
        check("err_cnt", err_cnt, exp_err[15:0]);
        check("err_flag", err_flag, exp_err != 0);
        check("sb_drained", exp_wcmd.size() + exp_wdat.size() + exp_rcmd.size(), 0);
        check("beats_returned", beat_idx, NWORDS);
        check("wr_done_timing", wr_done_cyc, wr_last + 1);
        check("rd_done_timing", rd_done_cyc, last_beat_cyc + 1);
        check("done_idle_bus", {app_en, app_wdf_wren}, 2'b00);
        if (full_rate) begin
            check("no_bubble", first_rcmd - first_wcmd, NWORDS);
            check("rd_rate", last_rcmd - first_rcmd, NWORDS - 1);
        end
    endtask

    function automatic logic [196:0] outvec();
        return {app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
                app_wdf_mask, wr_done, rd_done, err_cnt, err_flag};
    endfunction

    function automatic logic [196:0] resetvec();
        return {1'b0, 3'b000, BASE, 128'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};
    endfunction

    initial begin
        int viol, k, nerr;

        // Reset values, then calibration withheld for 200 cycles
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check("reset_outputs", outvec(), resetvec());
        prepare_run(20, 100);
        @(posedge sysclk); #2 rst_n = 1'b1;
        viol = 0;
        repeat (200) begin
            @(negedge sysclk);
            if (app_en || app_wdf_wren || wr_done || rd_done || err_flag || err_cnt != 0) viol++;
        end
        check("no_calib_idle", viol, 0);

        // Full-rate frame, loopback with 20-cycle latency
        @(posedge sysclk); #2 calib = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check("first_app_en", {app_en, app_wdf_wren}, 2'b11);
        check("wdf_mask", app_wdf_mask, 16'h0000);
        check_run(0, 1'b1);

        // Command backpressure on word 3
        do_reset();
        prepare_run(20, 100);
        bp_mode = 1;
        #1 calib = 1'b1;
        check_run(0, 1'b0);
        check("bp_stall_cycles", bp_stall, 5);
        check("bp_wren_once", bp_wren, 1);

        // Single corrupted beat, then stray beats after completion
        do_reset();
        prepare_run(20, 100);
        corrupt[5] = 1'b1;
        #1 calib = 1'b1;
        check_run(1, 1'b1);
        extra_beats = 3;
        repeat (8) @(negedge sysclk);
        check("done_ignores_beats", {rd_done, err_flag, err_cnt}, {1'b1, 1'b1, 16'd1});

        // Asynchronous reset during word 10 of the write phase
        do_reset();
        prepare_run(20, 100);
        #1 calib = 1'b1;
        k = 0;
        while (!(app_en && app_cmd == 3'b000 && app_addr == ADDR_W'(80)) && k < 500) begin
            @(negedge sysclk);
            k++;
        end
        check("reached_word10", app_addr, ADDR_W'(80));
        #1 rst_n = 1'b0;
        #1 check("async_reset", outvec(), resetvec());
        repeat (2) @(posedge sysclk);
        prepare_run(20, 100);
        #2 rst_n = 1'b1;
        check_run(0, 1'b1);

        // Randomised backpressure, latency and corruption
        for (int r = 0; r < 6; r++) begin
            do_reset();
            prepare_run($urandom_range(30, 1), $urandom_range(100, 30));
            nerr = 0;
            for (int n = 0; n < NWORDS; n++) begin
                corrupt[n] = ($urandom_range(7) == 0);
                if (corrupt[n]) nerr++;
            end
            extra_beats = 2;
            #1 calib = 1'b1;
            repeat (5) @(posedge sysclk);
            #2 calib = 1'b0;
            check_run(nerr, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
